iob_split_guard: RTL and testbench

Parametrised successor to the native-bus splitter. It routes one master request to one of `N_SLAVES` slaves, selected by an address field. Each transaction is registered and held. A per-transaction timeout and an unmapped-slave check close out any hung or invalid access with an error word. A sticky error/address capture is provided for firmware. It sits between the CPU data/peripheral bus and the peripheral slaves, and replaces the purely combinational split on buses where a hung slave must not stall the CPU.

---
 rtl/iob_split_guard_pkg.sv | 20 ++
 rtl/iob_timeout_cnt.sv | 20 ++
 rtl/iob_split_guard.sv | 105 ++++++++++
 tb/tb_iob_split_guard.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/iob_split_guard_pkg.sv
// iob_split_guard_pkg: shared interconnect field widths and the splitter FSM encoding.
package iob_split_guard_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
  // request is {valid, addr, wdata, wstrb}, response is {rdata, ready}
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/iob_timeout_cnt.sv
// iob_timeout_cnt: saturating busy-cycle counter, expired once TIMEOUT cycles have elapsed.
module iob_timeout_cnt
  import iob_split_guard_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
  assign o_expired = r_cnt == MAX;
endmodule

// File: rtl/iob_split_guard.sv
// iob_split_guard: registered one-of-N bus splitter with timeout abort, unmapped-slave
// error response and a sticky first-error address capture.
module iob_split_guard
  import iob_split_guard_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLAVES = 4,
  parameter int P_SLAVES = ADDR_W - 2,
  parameter int TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic [req_w(ADDR_W, DATA_W)-1:0] m_req,
  output logic [resp_w(DATA_W)-1:0] m_resp,
  output logic [N_SLAVES*req_w(ADDR_W, DATA_W)-1:0] s_req,
  input  logic [N_SLAVES*resp_w(DATA_W)-1:0] s_resp,
  output logic err,
  output logic [ADDR_W-1:0] err_addr,
  input  logic err_clr
);
  localparam int REQ_W = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);
  localparam int STRB_W = strb_w(DATA_W);
  localparam int SEL_W = sel_w(N_SLAVES);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_err_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [SEL_W-1:0] r_sel, w_sel;
  logic [RESP_W-1:0] w_sresp;
  logic r_err, w_valid, w_mapped, w_accept, w_busy, w_expired, w_err_set;
  assign w_valid = m_req[REQ_W-1];
  assign w_addr = m_req[STRB_W+DATA_W +: ADDR_W];
  assign w_sel = w_addr[P_SLAVES -: SEL_W];
  assign w_mapped = int'(w_sel) < N_SLAVES;
  assign w_busy = r_state == BUSY;
  assign w_accept = r_state == IDLE && w_valid;
  // only the latched slave's response is looked at; everything else is ignored
  always_comb begin
    w_sresp = '0;
    for (int i = 0; i < N_SLAVES; i++)
      w_sresp = (r_sel == SEL_W'(i)) ? s_resp[i*RESP_W +: RESP_W] : w_sresp;
  end
  // ready beats a coincident timeout
  assign w_err_set = (w_accept && !w_mapped) || (w_busy && !w_sresp[0] && w_expired);
  generate
    if (TIMEOUT > 0) begin : g_to
      iob_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to (
        .clk(clk),
        .rst(rst),
        .i_clr(w_accept),
        .i_en(w_busy),
        .o_expired(w_expired)
      );
    end else begin : g_no_to
      assign w_expired = 1'b0;
    end
  endgenerate
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !w_valid ? IDLE : w_mapped ? BUSY : RESP;
      BUSY: w_next = (w_sresp[0] || w_expired) ? RESP : BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    m_resp = (r_state == RESP) ? {r_rdata, 1'b1} : '0;
    s_req = '0;
    for (int i = 0; i < N_SLAVES; i++)
      s_req[i*REQ_W +: REQ_W] = {w_busy && r_sel == SEL_W'(i), r_addr, r_wdata, r_wstrb};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_sel <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= w_addr;
        r_wdata <= m_req[STRB_W +: DATA_W];
        r_wstrb <= m_req[STRB_W-1:0];
        r_sel <= w_sel;
      end
      if (w_err_set) r_rdata <= ERR_DATA;
      else if (w_busy && w_sresp[0]) r_rdata <= w_sresp[RESP_W-1:1];
      if (w_err_set) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= w_accept ? w_addr : r_addr;
      end else if (err_clr) begin
        r_err <= 1'b0;
        r_err_addr <= '0;
      end
    end
  end
  assign err = r_err;
  assign err_addr = r_err_addr;
endmodule

// File: tb/tb_iob_split_guard.sv
// tb_iob_split_guard: transaction-schedule model of the guarded splitter, checked every cycle.
module tb_iob_split_guard;
  localparam int AW = 32, DW = 32, NS = 3, PS = 31, TO = 8;
  localparam int SW = DW / 8, RQ = 1 + AW + DW + SW, RS = DW + 1;
  localparam logic [DW-1:0] ED = 32'hDEADBEEF;
  logic clk = 0, rst = 1, err_clr = 0, err;
  logic [RQ-1:0] m_req = '0;
  logic [RS-1:0] m_resp;
  logic [NS*RQ-1:0] s_req;
  logic [NS*RS-1:0] s_resp = '0;
  logic [AW-1:0] err_addr;
  int cyc = 0, errors = 0, checks = 0;
  bit chk_en = 0, rand_mode = 0;
  // current transaction schedule: accept interval, response interval, slave-valid window
  int t_acc = -10, t_resp = -10, t_vfrom = -10, t_vto = -20, t_sel = 0, t_lat = 0;
  bit t_map = 0, t_err = 0, e_err = 0;
  logic [DW-1:0] t_rdata = '0, t_sdata = '0, t_wdata = '0, e_wdata = '0;
  logic [AW-1:0] t_addr = '0, e_addr = '0, e_err_addr = '0;
  logic [SW-1:0] t_wstrb = '0, e_wstrb = '0;

  iob_split_guard #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .P_SLAVES(PS), .TIMEOUT(TO), .ERR_DATA(ED)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp), .s_req(s_req), .s_resp(s_resp),
    .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("m_ready", m_resp[0], cyc == t_resp);
    chk("m_rdata", m_resp[RS-1:1], (cyc == t_resp) ? t_rdata : '0);
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("s%0d_valid", i), s_req[i*RQ+RQ-1], t_map && i == t_sel && cyc >= t_vfrom && cyc <= t_vto);
      chk($sformatf("s%0d_fields", i), s_req[i*RQ +: RQ-1], {e_addr, e_wdata, e_wstrb});
    end
    chk("err", err, e_err);
    chk("err_addr", err_addr, e_err_addr);
  end

  task automatic cycle();
    logic rdy;
    logic [DW-1:0] d;
    @(posedge clk); #2;
    if (rst) begin
      t_acc = -10; t_resp = -10; t_map = 0; t_vfrom = -10; t_vto = -20;
      e_addr = '0; e_wdata = '0; e_wstrb = '0; e_err = 0; e_err_addr = '0;
      chk_en = 1;
    end else begin
      if (cyc == t_acc + 1) begin e_addr = t_addr; e_wdata = t_wdata; e_wstrb = t_wstrb; end
      if (cyc == t_resp && t_err) begin
        if (!e_err) e_err_addr = t_addr;
        e_err = 1;
      end else if (err_clr) begin
        e_err = 0; e_err_addr = '0;
      end
    end
    if (rst || m_resp[0] === 1'b1) m_req = {1'b0, 32'($urandom), 32'($urandom), 4'($urandom)};
    for (int i = 0; i < NS; i++) begin
      d = $urandom;
      if (t_map && i == t_sel && cyc >= t_vfrom && cyc <= t_vto) begin
        rdy = t_lat <= TO && cyc == t_vfrom + t_lat;
        if (rdy) d = t_sdata;
      end else rdy = $urandom_range(0, 3) == 0;
      s_resp[i*RS +: RS] = {d, rdy};
    end
    if (rand_mode) err_clr = $urandom_range(0, 7) == 0;
  endtask

  // lat > TO means the slave never answers
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                       input int lat, input logic [DW-1:0] sd);
    t_acc = cyc; t_addr = a; t_wdata = wd; t_wstrb = ws; t_lat = lat; t_sdata = sd;
    t_sel = int'(a[PS -: 2]);
    t_map = t_sel < NS;
    if (!t_map) begin t_resp = cyc + 1; t_rdata = ED; t_err = 1; end
    else if (lat <= TO) begin t_resp = cyc + lat + 2; t_rdata = sd; t_err = 0; end
    else begin t_resp = cyc + TO + 2; t_rdata = ED; t_err = 1; end
    t_vfrom = t_map ? cyc + 1 : -10;
    t_vto = t_map ? t_resp - 1 : -20;
    m_req = {1'b1, a, wd, ws};
  endtask

  task automatic wait_resp(output int lat);
    int n0, k;
    n0 = cyc; k = 0;
    do begin cycle(); k++; end while (m_resp[0] !== 1'b1 && k < 40);
    chk("resp_seen", m_resp[0], 1'b1);
    lat = cyc - n0;
  endtask

  initial begin
    int l, n;
    logic [AW-1:0] a;
    repeat (3) cycle();
    chk("rst_resp", m_resp, 0);
    chk("rst_valids", {s_req[3*RQ-1], s_req[2*RQ-1], s_req[RQ-1]}, 0);
    chk("rst_err_addr", err_addr, 0);
    rst = 0;
    cycle();
    issue(32'h4000_0010, 32'h0, 4'h0, 2, 32'h1234_5678);
    wait_resp(l);
    chk("rd_lat", l, 4);
    chk("rd_data", m_resp, {32'h1234_5678, 1'b1});
    chk("rd_err", err, 0);
    cycle();
    n = cyc;
    issue(32'h8000_0004, 32'hA5A5_5A5A, 4'b0011, 0, 32'h0);
    cycle();
    chk("wr_s2_req", s_req[2*RQ +: RQ], {1'b1, 32'h8000_0004, 32'hA5A5_5A5A, 4'b0011});
    wait_resp(l);
    chk("wr_lat", cyc - n, 2);
    cycle();
    issue(32'h8000_0000, 32'h1, 4'hF, 99, 32'h0);
    wait_resp(l);
    chk("to_lat", l, 10);
    chk("to_data", m_resp, {ED, 1'b1});
    chk("to_err", err, 1);
    chk("to_err_addr", err_addr, 32'h8000_0000);
    cycle();
    issue(32'hC000_0004, 32'h0, 4'b0011, 0, 32'h0);
    wait_resp(l);
    chk("um_lat", l, 1);
    chk("um_data", m_resp, {ED, 1'b1});
    chk("um_keep_addr", err_addr, 32'h8000_0000);
    err_clr = 1;
    cycle();
    err_clr = 0;
    chk("clr_err", err, 0);
    chk("clr_err_addr", err_addr, 0);
    err_clr = 1;
    issue(32'hC000_0100, 32'h0, 4'h0, 0, 32'h0);
    wait_resp(l);
    err_clr = 0;
    chk("clr_set_err", err, 1);
    chk("clr_set_addr", err_addr, 32'hC000_0100);
    cycle();
    issue(32'h4000_0000, 32'h0, 4'h0, TO, 32'h0BAD_F00D);
    wait_resp(l);
    chk("edge_lat", l, 10);
    chk("edge_data", m_resp, {32'h0BAD_F00D, 1'b1});
    chk("edge_err_addr", err_addr, 32'hC000_0100);
    cycle();
    issue(32'h0000_0040, 32'h55, 4'h1, 99, 32'h0);
    repeat (3) cycle();
    rst = 1;
    m_req[RQ-1] = 1'b0;
    cycle();
    rst = 0;
    chk("mid_rst_valids", {s_req[3*RQ-1], s_req[2*RQ-1], s_req[RQ-1]}, 0);
    chk("mid_rst_resp", m_resp, 0);
    chk("mid_rst_err", err, 0);
    issue(32'h0000_0020, 32'h0, 4'h0, 1, 32'hCAFE_0001);
    wait_resp(l);
    chk("post_rst_lat", l, 3);
    chk("post_rst_data", m_resp, {32'hCAFE_0001, 1'b1});
    rand_mode = 1;
    for (int k = 0; k < 200; k++) begin
      cycle();
      repeat ($urandom_range(0, 2)) cycle();
      a = $urandom;
      issue(a, $urandom, 4'($urandom), $urandom_range(0, TO + 3), $urandom);
      wait_resp(l);
    end
    rand_mode = 0;
    err_clr = 0;
    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
